// File: rtl/instruction_loader.sv
// instruction_loader: assembles a big-endian byte stream into 32-bit words and writes them bytewise into instruction memory.
// Optional LOADER_CHECKSUM_EN: a trailing XOR check byte is received after the last word.
module instruction_loader #(
    parameter int MEM_BYTES   = 512,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            baseAddress,
    input  logic [COUNT_WIDTH-1:0] wordCount,
    input  logic [7:0]             byteIn,
    input  logic                   byteValid,
    output logic                   byteReady,
    output logic                   memWriteEnable,
    output logic [31:0]            memWriteAddress,
    output logic [7:0]             memWriteData,
    output logic                   busy,
    output logic                   cpuStall,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [2:0] {IDLE, CHECK, RECV, WRITE, SUM, DONE} state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = SUM;
`else
    localparam state_t AFTER_LAST = DONE;
`endif
    state_t state, state_next;
    logic [31:0]            base;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] word_idx;
    logic [1:0]             byte_cnt;
    logic [31:0]            buffer;
    logic                   error_q;
    logic                   range_bad;
    logic                   take;
    logic                   last_word;
    logic [4:0]             lane;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif
    // End address is formed 33 bits wide so a huge count cannot wrap into range
    assign range_bad = (33'(base) + (33'(count) << 2) > 33'(MEM_BYTES)) || base[1:0] != 2'b00;
    assign take      = byteValid && byteReady;
    assign last_word = word_idx + COUNT_WIDTH'(1) == count;
    assign lane      = {~byte_cnt, 3'b000};
    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CHECK : IDLE;
            CHECK:   state_next = (range_bad || count == '0) ? DONE : RECV;
            RECV:    state_next = (take && byte_cnt == 2'd3) ? WRITE : RECV;
            WRITE:   state_next = byte_cnt == 2'd3 ? (last_word ? AFTER_LAST : RECV) : WRITE;
            SUM:     state_next = take ? DONE : SUM;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            base     <= '0;
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
            error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    base     <= baseAddress;
                    count    <= wordCount;
                    word_idx <= '0;
                    byte_cnt <= '0;
                    error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum     <= '0;
`endif
                end
                CHECK: if (range_bad) error_q <= 1'b1;
                RECV: if (take) begin
                    buffer[lane +: 8] <= byteIn;
                    byte_cnt          <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum              <= csum ^ byteIn;
`endif
                end
                WRITE: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) word_idx <= word_idx + COUNT_WIDTH'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                SUM: if (take && byteIn != csum) error_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end
    always_comb begin
        busy            = state != IDLE;
        cpuStall        = state != IDLE;
        byteReady       = state == RECV || state == SUM;
        memWriteEnable  = state == WRITE;
        memWriteAddress = state == WRITE ? base + (32'(word_idx) << 2) + 32'(byte_cnt) : 32'h0;
        memWriteData    = state == WRITE ? buffer[lane +: 8] : 8'h00;
        done            = state == DONE;
        error           = error_q;
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized self-checking bench; expected writes come from a byte-stream model.
module tb_instruction_loader;
    logic        clock = 0, reset_n = 0, start = 0, byteValid = 0;
    logic [31:0] baseAddress = 0;
    logic [15:0] wordCount = 0;
    logic [7:0]  byteIn = 0;
    logic        byteReady, memWriteEnable, busy, cpuStall, done, error;
    logic [31:0] memWriteAddress;
    logic [7:0]  memWriteData;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    instruction_loader dut (
        .clock(clock), .reset_n(reset_n), .start(start), .baseAddress(baseAddress),
        .wordCount(wordCount), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .memWriteEnable(memWriteEnable), .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
        .busy(busy), .cpuStall(cpuStall), .done(done), .error(error)
    );
    always #5 clock = ~clock;
    int compared = 0, mismatched = 0, cyc = 0;
    int done_n, done_cyc, rdy_viol, acc_n, start_cyc, fourth_cyc, exp_acc;
    logic [31:0] act_a[$], exp_a[$];
    logic [7:0]  act_d[$], exp_d[$], feed_q[$];
    int          wr_cyc[$];
    logic [7:0]  exp_x;
    bit          exp_err;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (memWriteEnable) begin
            act_a.push_back(memWriteAddress);
            act_d.push_back(memWriteData);
            wr_cyc.push_back(cyc);
            if (byteReady) rdy_viol++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end
    task automatic gen(input int nbytes);
        feed_q.delete();
        repeat (nbytes) feed_q.push_back(8'($urandom));
    endtask
    // Reference: stream byte j lands at base+j; range rule checked on a 33-bit end address
    task automatic model(input logic [31:0] base, input int cnt);
        logic [32:0] top;
        bit bad;
        top = {1'b0, base} + 33'(4 * cnt);
        bad = top > 33'd512 || base[1:0] != 2'b00;
        exp_a.delete(); exp_d.delete();
        exp_x = 8'h00;
        exp_err = bad;
        if (!bad)
            for (int j = 0; j < 4 * cnt; j++) begin
                exp_a.push_back(base + 32'(j));
                exp_d.push_back(feed_q[j]);
                exp_x ^= feed_q[j];
            end
        exp_acc = (bad || cnt == 0) ? 0 : 4 * cnt + int'(CK);
        if (CK && !bad && cnt > 0 && feed_q.size() == 4 * cnt) feed_q.push_back(exp_x);
    endtask
    task automatic load(input logic [31:0] base, input int cnt, input bit toggle, input int stop_after, input bit busy_start);
        bit acc;
        act_a.delete(); act_d.delete(); wr_cyc.delete();
        done_n = 0; acc_n = 0; rdy_viol = 0; fourth_cyc = -1;
        @(negedge clock);
        start = 1; baseAddress = base; wordCount = 16'(cnt); start_cyc = cyc;
        @(posedge clock);
        for (int t = 0; t < 400 && done_n == 0 && !(stop_after > 0 && acc_n >= stop_after); t++) begin
            @(negedge clock);
            start = busy_start && t == 3;
            if (busy_start && t == 3) begin baseAddress = 32'h2; wordCount = 16'd0; end
            byteValid = feed_q.size() > 0 && (!toggle || t[0] == 1'b0);
            byteIn = feed_q.size() > 0 ? feed_q[0] : 8'h00;
            acc = byteValid && byteReady;
            if (acc && acc_n == 3) fourth_cyc = cyc;
            @(posedge clock);
            if (acc) begin
                void'(feed_q.pop_front());
                acc_n++;
            end
        end
        @(negedge clock);
        byteValid = 0; start = 0;
    endtask
    task automatic test_reset;
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        compared++;
        if ({byteReady, memWriteEnable, busy, cpuStall, done, error} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 000000", {byteReady, memWriteEnable, busy, cpuStall, done, error});
        end
        compared++;
        if ({memWriteAddress, memWriteData} !== 40'h0) begin
            mismatched++;
            $display("FAIL reset_bus: got addr %h data %h required 0", memWriteAddress, memWriteData);
        end
        reset_n = 1;
    endtask
    task automatic test_single_word;
        int e;
        feed_q = '{8'h01, 8'h00, 8'h40, 8'h20};
        model(32'h0, 1);
        load(32'h0, 1, 0, 0, 0);
        e = act_a.size() == exp_a.size() ? -1 : 0;
        for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
        compared++;
        if (e != -1) begin mismatched++; $display("FAIL single_writes: %0d writes, required %0d, first bad %0d", act_a.size(), exp_a.size(), e); end
        compared++;
        if (wr_cyc.size() != 4 || wr_cyc[0] != fourth_cyc + 1 || wr_cyc[3] != fourth_cyc + 4) begin
            mismatched++;
            $display("FAIL single_timing: %0d writes starting cycle %0d, required 4 from cycle %0d", wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] : -1, fourth_cyc + 1);
        end
        compared++;
        if (done_n != 1 || error !== exp_err) begin mismatched++; $display("FAIL single_done: done %0d error %b, required 1 %b", done_n, error, exp_err); end
        compared++;
        if (busy !== 1'b0 || cpuStall !== 1'b0 || acc_n != exp_acc) begin
            mismatched++;
            $display("FAIL single_idle: busy %b stall %b accepted %0d, required 0 0 %0d", busy, cpuStall, acc_n, exp_acc);
        end
    endtask
    task automatic test_multi_word;
        int e;
        gen(12);
        model(32'h10, 3);
        load(32'h10, 3, 1, 0, 0);
        e = act_a.size() == exp_a.size() ? -1 : 0;
        for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
        compared++;
        if (e != -1) begin mismatched++; $display("FAIL multi_writes: %0d writes, required %0d, first bad %0d", act_a.size(), exp_a.size(), e); end
        compared++;
        if (rdy_viol != 0 || acc_n != exp_acc) begin
            mismatched++;
            $display("FAIL multi_handshake: ready-in-write %0d accepted %0d, required 0 %0d", rdy_viol, acc_n, exp_acc);
        end
        compared++;
        if (done_n != 1 || error !== exp_err) begin mismatched++; $display("FAIL multi_done: done %0d error %b, required 1 %b", done_n, error, exp_err); end
    endtask
    task automatic test_range;
        logic [31:0] bases[3] = '{32'h1F8, 32'h2, 32'h1FC};
        int cnts[3] = '{3, 1, 1};
        logic [31:0] b;
        int c, e;
        for (int k = 0; k < 9; k++) begin
            b = k < 3 ? bases[k] : 32'($urandom_range(0, 32'h210));
            c = k < 3 ? cnts[k] : int'($urandom_range(0, 4));
            gen(4 * c);
            model(b, c);
            load(b, c, k[0], 0, 0);
            e = act_a.size() == exp_a.size() ? -1 : 0;
            for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
            compared++;
            if (e != -1) begin mismatched++; $display("FAIL range_writes base %h cnt %0d: %0d writes, required %0d", b, c, act_a.size(), exp_a.size()); end
            compared++;
            if (done_n != 1 || error !== exp_err || acc_n != exp_acc) begin
                mismatched++;
                $display("FAIL range_result base %h cnt %0d: done %0d error %b acc %0d, required 1 %b %0d", b, c, done_n, error, acc_n, exp_err, exp_acc);
            end
            if (exp_err) begin
                compared++;
                if (done_cyc - start_cyc != 2) begin mismatched++; $display("FAIL range_latency base %h: done after %0d cycles, required 2", b, done_cyc - start_cyc); end
            end
        end
    endtask
    task automatic test_zero_count;
        int e;
        act_a.delete(); act_d.delete(); wr_cyc.delete();
        @(negedge clock);
        done_n = 0;
        start = 1; baseAddress = 32'h40; wordCount = 16'd0; start_cyc = cyc;
        @(negedge clock);
        wordCount = 16'd5;
        @(negedge clock);
        @(negedge clock);
        start = 0;
        repeat (6) @(negedge clock);
        compared++;
        if (done_n != 1 || done_cyc - start_cyc != 2 || act_a.size() != 0 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_count: done %0d after %0d writes %0d error %b, required 1 2 0 0", done_n, done_cyc - start_cyc, act_a.size(), error);
        end
        gen(4);
        model(32'h0, 1);
        load(32'h0, 1, 0, 0, 1);
        e = act_a.size() == exp_a.size() ? -1 : 0;
        for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
        compared++;
        if (e != -1 || done_n != 1 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_start: writes %0d done %0d error %b, required %0d 1 0", act_a.size(), done_n, error, exp_a.size());
        end
    endtask
    task automatic test_reset_mid;
        int e;
        gen(8);
        model(32'h80, 2);
        load(32'h80, 2, 0, 6, 0);
        compared++;
        if (act_a.size() != 4 || acc_n != 6) begin mismatched++; $display("FAIL mid_prefix: writes %0d accepted %0d, required 4 6", act_a.size(), acc_n); end
        reset_n = 0;
        @(posedge clock);
        @(negedge clock);
        compared++;
        if ({byteReady, memWriteEnable, busy, cpuStall, done, error, memWriteAddress, memWriteData} !== 46'h0) begin
            mismatched++;
            $display("FAIL mid_reset: ctrl %b addr %h data %h, required all 0", {byteReady, memWriteEnable, busy, cpuStall, done, error}, memWriteAddress, memWriteData);
        end
        reset_n = 1;
        gen(8);
        model(32'h80, 2);
        load(32'h80, 2, 0, 0, 0);
        e = act_a.size() == exp_a.size() ? -1 : 0;
        for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
        compared++;
        if (e != -1 || done_n != 1 || error !== 1'b0 || acc_n != exp_acc) begin
            mismatched++;
            $display("FAIL mid_reload: writes %0d done %0d error %b acc %0d, required %0d 1 0 %0d", act_a.size(), done_n, error, acc_n, exp_a.size(), exp_acc);
        end
    endtask
    task automatic test_checksum;
        logic [7:0] chk[2] = '{8'h61, 8'h60};
        int e;
        for (int k = 0; k < 2; k++) begin
            feed_q = '{8'h01, 8'h00, 8'h40, 8'h20, chk[k]};
            model(32'h0, 1);
            exp_err = CK && chk[k] != exp_x;
            load(32'h0, 1, 0, 0, 0);
            e = act_a.size() == exp_a.size() ? -1 : 0;
            for (int i = 0; i < act_a.size() && e == -1; i++) if (act_a[i] !== exp_a[i] || act_d[i] !== exp_d[i]) e = i;
            compared++;
            if (e != -1 || done_n != 1) begin mismatched++; $display("FAIL sum_writes chk %h: writes %0d done %0d, required %0d 1", chk[k], act_a.size(), done_n, exp_a.size()); end
            compared++;
            if (error !== exp_err || acc_n != exp_acc) begin
                mismatched++;
                $display("FAIL sum_result chk %h: error %b accepted %0d, required %b %0d", chk[k], error, acc_n, exp_err, exp_acc);
            end
            byteValid = feed_q.size() > 0;
            byteIn = chk[k];
            repeat (3) @(negedge clock);
            compared++;
            if (byteReady !== 1'b0 || feed_q.size() != 1 - int'(CK)) begin
                mismatched++;
                $display("FAIL sum_leftover chk %h: ready %b left %0d, required 0 %0d", chk[k], byteReady, feed_q.size(), 1 - int'(CK));
            end
            byteValid = 0;
        end
    endtask
    initial begin
        test_reset;
        test_single_word;
        test_multi_word;
        test_range;
        test_zero_count;
        test_reset_mid;
        test_checksum;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Sequential write-side counterpart to the byte-addressed, big-endian instruction memory.
- Accepts a stream of bytes over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction word.
- Issues each word as four byte writes (MSB first) to the instruction memory's write port.
- Holds the CPU stalled until the load completes. Used for boot-time program loading in place of hard-coded initial contents.

Parameters:
MEM_BYTES, 512, size of the target instruction memory in bytes; writes beyond it are rejected.
COUNT_WIDTH, 16, width of the word-count input.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
baseAddress  input  32  byte address of the first word; latched on start
wordCount  input  COUNT_WIDTH  number of 32-bit words to load; latched on start
byteIn  input  8  incoming program byte, stream order = big-endian (MSB of word first)
byteValid  input  1  byteIn is valid
byteReady  output  1  loader can accept a byte this cycle
memWriteEnable  output  1  byte write strobe to instruction memory
memWriteAddress  output  32  byte address of the write
memWriteData  output  8  byte to write
busy  output  1  high in every state except IDLE
cpuStall  output  1  equals busy; holds PC/fetch
done  output  1  one-cycle pulse at the end of a load (success or error)
error  output  1  sticky until next accepted start; set on range violation (or checksum mismatch)

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, byte/word counters are 0, and the word buffer is 0.
  - Reset mid-load abandons the load; bytes already written stay in memory.
- States:
  - IDLE:
    - start=1 latches baseAddress/wordCount, clears error, and goes to CHECK.
    - start is ignored in all other states.
  - CHECK (1 cycle):
    - If baseAddress+4*wordCount > MEM_BYTES (computed 33 bits wide, no wrap) or baseAddress[1:0]!=0: set error and go to DONE with no writes.
    - Else if wordCount==0: go to DONE.
    - Else: go to RECV.
  - RECV:
    - byteReady=1. A byte is accepted on a clock edge where byteValid && byteReady.
    - Byte k of the word (k=0..3) goes to buffer bits [31-8k -: 8].
    - When the 4th byte is accepted, go to WRITE.
    - byteValid=0 simply holds state; there is no timeout.
  - WRITE (exactly 4 cycles):
    - byteReady=0, memWriteEnable=1.
    - memWriteAddress = baseAddress + 4*wordIndex + i, for i=0..3.
    - memWriteData = buffer[31-8i -: 8].
    - After i=3, wordIndex increments. If wordIndex reaches wordCount, go to DONE (or SUM, see below); else go to RECV.
  - DONE (1 cycle): done=1, then go to IDLE.
- Outputs are registered (Moore). memWriteEnable, memWriteAddress and memWriteData are 0 outside WRITE.
- Throughput: 1 word per 8 cycles minimum (4 receive + 4 write).
- Latency: the first write occurs on the cycle after the 4th byte is accepted.
- A byte presented while byteReady=0 is not consumed; the source must hold it.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN
- Defined:
  - After the last WRITE, go to state SUM. byteReady=1 and one additional byte is accepted.
  - If that byte != XOR of all 4*wordCount data bytes, set error.
  - Then go to DONE.
  - With wordCount==0 the SUM step is skipped.
  - The running XOR resets on start.
- Not defined: no SUM state and no XOR register; DONE follows the last WRITE directly.

Test Plan:
1. Load one word:
   - Stimulus: reset, then start with base=0, count=1; stream 0x01,0x00,0x40,0x20.
   - Required: writes addr0=0x01, 1=0x00, 2=0x40, 3=0x20 on 4 consecutive cycles; done pulse; error=0; busy/cpuStall low afterwards.
2. Load three words at base 0x10 with byteValid toggling every other cycle:
   - Required: 12 writes at 0x10..0x1B, in order and correct.
   - Required: byteReady=0 during each WRITE burst, and no byte is lost or duplicated.
3. Range violations:
   - base=0x1F8, count=3: error=1 and done pulse 2 cycles after start, with zero writes.
   - base=0x002, count=1: same response (misaligned).
   - base=0x1FC, count=1: completes without error.
4. wordCount=0:
   - Required: done 2 cycles after start, no writes, error=0.
   - start asserted while busy has no effect.
5. Reset mid-load:
   - Stimulus: reset_n=0 after the 2nd byte of word 1.
   - Required: all outputs 0 on the next edge, state IDLE; a fresh start then loads correctly from byte 0.
6. Checksum (LOADER_CHECKSUM_EN):
   - Word 0x01004020 followed by check byte 0x61 gives error=0.
   - The same word followed by check byte 0x60 gives error=1 with done.
   - Without the macro, the same stream leaves the 5th byte unaccepted after done.
